fft_bitrev_reorder: RTL and testbench

//  Output reorder buffer downstream of the final SDF radix-2 stage. Serial

---
 rtl/fft_bitrev_reorder.sv | 227 ++++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Output reorder buffer behind the last SDF radix-2 stage. Each incoming
//   frame arrives in bit-reversed bin order. It is written at bit-reversed
//   addresses into one half of a ping-pong RAM. It is then streamed out in
//   natural bin order with valid/ready flow control.
// Ports
//   clk, rst        clock, synchronous active-high reset (overrides enable)
//   enable          global clock enable; low freezes every register
//   in_valid/in_sof input sample strobe / first-sample-of-frame marker
//   in_re/in_im     signed input sample
//   out_valid/ready output handshake
//   out_sof         high with bin 0 of each frame
//   out_index       natural-order bin index of the presented sample
//   out_re/out_im   signed output sample
//   overflow        sticky: a frame was dropped because no bank was free
module fft_bitrev_reorder #(
  parameter int FFT_N = 1024,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic signed [WIDTH-1:0]   in_re,
  input  logic signed [WIDTH-1:0]   in_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sof,
  output logic [$clog2(FFT_N)-1:0]  out_index,
  output logic signed [WIDTH-1:0]   out_re,
  output logic signed [WIDTH-1:0]   out_im,
  output logic                      overflow
);

  localparam int AW = $clog2(FFT_N);
  localparam logic [AW-1:0] LAST_CNT = AW'(FFT_N - 1);
  localparam logic [AW-1:0] ZERO_CNT = {AW{1'b0}};

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  // Ping-pong storage: address MSB selects the bank, data is {re, im}.
  logic [2*WIDTH-1:0] r_mem [2*FFT_N];

  logic              r_wr_bank;
  logic [AW-1:0]     r_wr_cnt;
  logic              r_dropping;
  logic              r_overflow;
  logic [1:0]        r_full;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rd_bank;
  logic [AW-1:0]     r_rd_cnt;
  logic              r_out_valid;
  logic              r_out_sof;
  logic [AW-1:0]     r_out_index;
  logic signed [WIDTH-1:0] r_out_re;
  logic signed [WIDTH-1:0] r_out_im;

  logic              w_wr_fire;
  logic [AW-1:0]     w_wr_cnt;
  logic              w_wr_first;
  logic              w_wr_last;
  logic              w_rd_frees_wr;
  logic              w_drop;
  logic              w_mem_we;
  logic              w_rd_issue;
  logic              w_rd_last;

  // Write-side decode: effective count, frame-drop decision and RAM write enable.
  always_comb begin
    w_wr_fire = enable & in_valid & ~rst;
    if (in_sof) begin
      w_wr_cnt = ZERO_CNT;
    end else begin
      w_wr_cnt = r_wr_cnt;
    end
    w_wr_first = (w_wr_cnt == ZERO_CNT);
    w_wr_last  = (w_wr_cnt == LAST_CNT);
    // A bank whose final read happens on this very edge is already free:
    // every address has been read, so the new frame may start writing it.
    w_rd_frees_wr = w_rd_last & (r_rd_bank == r_wr_bank);
    if (w_wr_first) begin
      w_drop = r_full[r_wr_bank] & ~w_rd_frees_wr;
    end else begin
      w_drop = r_dropping;
    end
    w_mem_we = w_wr_fire & ~w_drop;
  end

  // RAM write port; contents are not reset, the bank flags decide validity.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[{r_wr_bank, bitrev(w_wr_cnt)}] <= {in_re, in_im};
    end
  end

  // Write counter, bank pointer, drop tracking and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= ZERO_CNT;
      r_dropping <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_wr_fire) begin
      r_dropping <= w_drop;
      if (w_drop & w_wr_first) begin
        r_overflow <= 1'b1;
      end
      if (w_wr_last) begin
        r_wr_cnt <= ZERO_CNT;
        // A dropped frame leaves the pointer so the next frame retries the bank.
        if (!w_drop) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end else begin
        r_wr_cnt <= w_wr_cnt + AW'(1'b1);
      end
    end
  end

  // Bank FULL flags: set by the last write of a frame, cleared by its last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_mem_we & w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_last) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (enable) begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next state; stays in STREAM across frames when the other bank is ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = S_STREAM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_rd_last) begin
          w_state_nxt = r_full[~r_rd_bank] ? S_STREAM : S_IDLE;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read FSM outputs: issue a RAM read whenever the output register can take it.
  always_comb begin
    w_rd_issue = 1'b0;
    w_rd_last  = 1'b0;
    case (r_state)
      S_STREAM: begin
        w_rd_issue = enable & (out_ready | ~r_out_valid);
        w_rd_last  = w_rd_issue & (r_rd_cnt == LAST_CNT);
      end
      default: begin
        w_rd_issue = 1'b0;
        w_rd_last  = 1'b0;
      end
    endcase
  end

  // Read counter and output register; the RAM read lands directly in out_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= ZERO_CNT;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_index <= ZERO_CNT;
      r_out_re    <= {WIDTH{1'b0}};
      r_out_im    <= {WIDTH{1'b0}};
    end else if (w_rd_issue) begin
      r_out_valid <= 1'b1;
      r_out_sof   <= (r_rd_cnt == ZERO_CNT);
      r_out_index <= r_rd_cnt;
      {r_out_re, r_out_im} <= r_mem[{r_rd_bank, r_rd_cnt}];
      if (r_rd_cnt == LAST_CNT) begin
        r_rd_cnt  <= ZERO_CNT;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_cnt <= r_rd_cnt + AW'(1'b1);
      end
    end else if (enable & out_ready) begin
      // Sample consumed with nothing behind it: out_sof must drop with out_valid.
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_index = r_out_index;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
  localparam int N  = 8;
  localparam int BN = 1024;

  logic clk = 1'b0;
  logic rst, enable, in_valid, in_sof, out_ready;
  logic signed [15:0] in_re, in_im;

  logic s_out_valid, s_out_sof, s_overflow;
  logic [2:0] s_out_index;
  logic signed [15:0] s_out_re, s_out_im;

  logic b_out_valid, b_out_sof, b_overflow;
  logic [9:0] b_out_index;
  logic signed [15:0] b_out_re, b_out_im;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic signed [15:0] exp_re;
    logic signed [15:0] exp_im;
  } vec_t;
  vec_t tbl [N];

  typedef struct {
    int idx;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic sof;
    int cyc;
  } obs_t;
  obs_t q[$];
  obs_t bq[$];

  bit pat [4];

  fft_bitrev_reorder #(.FFT_N(N), .WIDTH(16)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sof(s_out_sof), .out_index(s_out_index), .out_re(s_out_re),
    .out_im(s_out_im), .overflow(s_overflow)
  );

  fft_bitrev_reorder #(.FFT_N(BN), .WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sof(b_out_sof), .out_index(b_out_index), .out_re(b_out_re),
    .out_im(b_out_im), .overflow(b_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int brev10(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) begin
      r = r | (((v >> i) & 1) << (9 - i));
    end
    return r;
  endfunction

  // Output collectors plus the out_sof rule, sampled mid-cycle.
  always @(negedge clk) begin
    check("sof_rule", 32'(s_out_sof), 32'(s_out_valid && (s_out_index == 3'd0)));
    if (!rst && enable && s_out_valid && out_ready)
      q.push_back('{int'(s_out_index), s_out_re, s_out_im, s_out_sof, cyc});
    if (!rst && enable && b_out_valid && out_ready)
      bq.push_back('{int'(b_out_index), b_out_re, b_out_im, b_out_sof, cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    bq.delete();
  endtask

  task automatic send_frame(input int f, input int n, input bit sof);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_sof   = sof && (k == 0);
      in_re    = tbl[k].in_re + 16'(f * 16);
      in_im    = tbl[k].in_im;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check(nm, 32'(q.size()), 32'(n));
  endtask

  task automatic check_frame(input int f, input int pos);
    logic signed [15:0] er;
    for (int i = 0; i < N; i++) begin
      er = tbl[i].exp_re + 16'(f * 16);
      if (pos + i < q.size()) begin
        check("frm_idx", 32'(q[pos+i].idx), 32'(i));
        check("frm_re",  32'(q[pos+i].re), 32'(er));
        check("frm_im",  32'(q[pos+i].im), 32'(tbl[i].exp_im));
        check("frm_sof", 32'(q[pos+i].sof), 32'(i == 0));
      end else begin
        check("frm_missing", 32'(q.size()), 32'(pos + i + 1));
      end
    end
  endtask

  initial begin
    logic hv;
    logic [2:0] hi;
    logic signed [15:0] hr, him;
    int c;
    int br;
    logic signed [15:0] e16;

    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    in_re = 16'sd0; in_im = 16'sd0; out_ready = 1'b0;
    // Arrival position k carries value k; natural bin n holds arrival bitrev(n).
    tbl[0] = '{16'sd0, 16'sh8000, 16'sd0, 16'sh8000};
    tbl[1] = '{16'sd1, 16'sh8001, 16'sd4, 16'sh8004};
    tbl[2] = '{16'sd2, 16'sh8002, 16'sd2, 16'sh8002};
    tbl[3] = '{16'sd3, 16'sh8003, 16'sd6, 16'sh8006};
    tbl[4] = '{16'sd4, 16'sh8004, 16'sd1, 16'sh8001};
    tbl[5] = '{16'sd5, 16'sh8005, 16'sd5, 16'sh8005};
    tbl[6] = '{16'sd6, 16'sh8006, 16'sd3, 16'sh8003};
    tbl[7] = '{16'sd7, 16'sh8007, 16'sd7, 16'sh8007};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(s_out_valid), 32'd0);
    check("rst_sof",   32'(s_out_sof),   32'd0);
    check("rst_index", 32'(s_out_index), 32'd0);
    check("rst_re",    32'(s_out_re),    32'd0);
    check("rst_im",    32'(s_out_im),    32'd0);
    check("rst_ovf",   32'(s_overflow),  32'd0);
    rst = 1'b0;

    // Test 1: single frame, latency, enable stall.
    out_ready = 1'b1;
    send_frame(0, N, 1'b1);
    check("t1_lat_t0", 32'(s_out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_lat_t1", 32'(s_out_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_lat_t2", 32'(s_out_valid), 32'd1);
    check("t1_lat_idx", 32'(s_out_index), 32'd0);
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("t1_en_valid", 32'(s_out_valid), 32'd1);
      check("t1_en_idx",   32'(s_out_index), 32'd0);
    end
    enable = 1'b1;
    wait_q(N, 30, "t1_count");
    repeat (5) @(posedge clk);
    #1;
    check("t1_count_end", 32'(q.size()), 32'(N));
    check_frame(0, 0);
    check("t1_ovf", 32'(s_overflow), 32'd0);

    // Test 2: four back-to-back frames, no bubble.
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(f, N, 1'b1);
    wait_q(4 * N, 40, "t2_count");
    for (int f = 0; f < 4; f++) check_frame(f, f * N);
    for (int i = 1; i < q.size(); i++)
      check("t2_contig", 32'(q[i].cyc - q[i-1].cyc), 32'd1);
    check("t2_ovf", 32'(s_overflow), 32'd0);

    // Test 3: ready pattern 1,0,0,1 with hold checks.
    do_reset();
    out_ready = 1'b0;
    send_frame(0, N, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    c = 0;
    while (q.size() < N && c < 60) begin
      out_ready = pat[c % 4];
      hv = s_out_valid && !out_ready;
      hi = s_out_index; hr = s_out_re; him = s_out_im;
      @(posedge clk); #1;
      if (hv) begin
        check("t3_hold_valid", 32'(s_out_valid), 32'd1);
        check("t3_hold_idx",   32'(s_out_index), 32'(hi));
        check("t3_hold_re",    32'(s_out_re),    32'(hr));
        check("t3_hold_im",    32'(s_out_im),    32'(him));
      end
      c++;
    end
    out_ready = 1'b1;
    wait_q(N, 10, "t3_count");
    check_frame(0, 0);

    // Test 4: ready held low, three frames, third dropped.
    do_reset();
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(f, N, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ovf_set", 32'(s_overflow), 32'd1);
    check("t4_none_out", 32'(q.size()), 32'd0);
    check("t4_head_idx", 32'(s_out_index), 32'd0);
    out_ready = 1'b1;
    wait_q(2 * N, 60, "t4_count");
    repeat (12) @(posedge clk);
    #1;
    check("t4_count_end", 32'(q.size()), 32'(2 * N));
    check_frame(0, 0);
    check_frame(1, N);
    check("t4_ovf_sticky", 32'(s_overflow), 32'd1);

    // Test 5: partial frame abandoned by in_sof.
    do_reset();
    out_ready = 1'b1;
    send_frame(0, 5, 1'b1);
    send_frame(1, N, 1'b1);
    wait_q(N, 30, "t5_count");
    repeat (12) @(posedge clk);
    #1;
    check("t5_count_end", 32'(q.size()), 32'(N));
    check_frame(1, 0);
    check("t5_ovf", 32'(s_overflow), 32'd0);

    // Test 6: reset mid-output, then a 1024-point ramp.
    do_reset();
    out_ready = 1'b1;
    send_frame(2, N, 1'b1);
    wait_q(3, 20, "t6_mid");
    rst = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("t6_valid", 32'(s_out_valid), 32'd0);
    check("t6_sof",   32'(s_out_sof),   32'd0);
    check("t6_index", 32'(s_out_index), 32'd0);
    check("t6_re",    32'(s_out_re),    32'd0);
    check("t6_im",    32'(s_out_im),    32'd0);
    check("t6_ovf",   32'(s_overflow),  32'd0);
    check("t6_bvalid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    q.delete();
    bq.delete();
    repeat (12) @(posedge clk);
    #1;
    check("t6_empty_q", 32'(q.size()), 32'd0);
    check("t6_empty_valid", 32'(s_out_valid), 32'd0);
    for (int k = 0; k < BN; k++) begin
      in_valid = 1'b1;
      in_sof   = (k == 0);
      in_re    = 16'(k);
      in_im    = ~16'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    c = 0;
    while (bq.size() < BN && c < 1300) begin
      @(posedge clk); #1;
      c++;
    end
    check("t6_bcount", 32'(bq.size()), 32'(BN));
    for (int n = 0; n < bq.size(); n++) begin
      br  = brev10(n);
      e16 = 16'(br);
      check("t6_bidx", 32'(bq[n].idx), 32'(n));
      check("t6_bre",  32'(bq[n].re),  32'(e16));
      e16 = ~16'(br);
      check("t6_bim",  32'(bq[n].im),  32'(e16));
      check("t6_bsof", 32'(bq[n].sof), 32'(n == 0));
    end
    check("t6_bovf", 32'(b_overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
